// File: rtl/svm_multilabel_seq_if.sv
// Input-beat and result handshake bundle for the sequential multi-label SVM.
interface svm_multilabel_seq_if #(
  parameter int NBITS         = 5,
  parameter int F_WIDTH       = 4,
  parameter int LOG_F_WIDTH   = $clog2(F_WIDTH),
  parameter int SUP_WIDTH     = 164,
  parameter int LOG_SUP_WIDTH = $clog2(SUP_WIDTH),
  parameter int NUM_LABELS    = 2,
  parameter int ACC_W         = 3*NBITS+LOG_F_WIDTH+LOG_SUP_WIDTH+1
);
  logic [NBITS*F_WIDTH-1:0]           in_features;
  logic [NBITS*SUP_WIDTH*F_WIDTH-1:0] in_support;
  logic [NBITS*SUP_WIDTH-1:0]         in_alpha;
  logic [ACC_W-1:0]                   in_intercept;
  logic [LOG_SUP_WIDTH:0]             in_num_sv;
  logic                               fin_valid;
  logic                               fin_ready;
  logic [NUM_LABELS-1:0]              dout_labels;
  logic [NUM_LABELS*ACC_W-1:0]        dout_scores;
  logic                               dout_valid;
  logic                               dout_ready;

  modport master (
    output in_features, in_support, in_alpha, in_intercept, in_num_sv, fin_valid, dout_ready,
    input  fin_ready, dout_labels, dout_scores, dout_valid
  );

  modport slave (
    input  in_features, in_support, in_alpha, in_intercept, in_num_sv, fin_valid, dout_ready,
    output fin_ready, dout_labels, dout_scores, dout_valid
  );
endinterface

// File: rtl/svm_multilabel_seq.sv
// Sequential linear-SVM classifier: one input beat per label, NPARALLEL
// support vectors MACed per cycle, all labels and scores emitted together.
module svm_multilabel_seq #(
  parameter int NBITS         = 5,
  parameter int F_WIDTH       = 4,
  parameter int LOG_F_WIDTH   = $clog2(F_WIDTH),
  parameter int SUP_WIDTH     = 164,
  parameter int LOG_SUP_WIDTH = $clog2(SUP_WIDTH),
  parameter int NPARALLEL     = 16,
  parameter int NUM_LABELS    = 2,
  parameter int ACC_W         = 3*NBITS+LOG_F_WIDTH+LOG_SUP_WIDTH+1
) (
  input logic                 clk,
  input logic                 rst,
  svm_multilabel_seq_if.slave bus
);
  localparam int PROD_W = 2*NBITS;
  localparam int DOT_W  = 2*NBITS+LOG_F_WIDTH;
  localparam int TERM_W = 3*NBITS+LOG_F_WIDTH;
  localparam int CNT_W  = LOG_SUP_WIDTH+1;
  localparam int IDX_W  = (NUM_LABELS > 1) ? $clog2(NUM_LABELS) : 1;
  localparam int unsigned NB_U   = NBITS;
  localparam int unsigned F_U    = F_WIDTH;
  localparam int unsigned NPAR_U = NPARALLEL;

  typedef enum logic [1:0] {IDLE, COMPUTE, FINISH, DOUT} state_t;

  state_t state, state_next;

  logic [NBITS*F_WIDTH-1:0]           features_r;
  logic [NBITS*SUP_WIDTH*F_WIDTH-1:0] support_r;
  logic [NBITS*SUP_WIDTH-1:0]         alpha_r;
  logic signed [ACC_W-1:0]            intercept_r;
  logic [CNT_W-1:0]                   n_r, last_group_r, group_r;
  logic [CNT_W-1:0]                   n_in, last_group_in;
  logic signed [ACC_W-1:0]            acc_r, group_sum, score;
  logic [IDX_W-1:0]                   idx_r;
  logic [NUM_LABELS-1:0]              labels_r;
  logic [NUM_LABELS*ACC_W-1:0]        scores_r;

  logic signed [DOT_W-1:0]  dot;
  logic signed [TERM_W-1:0] term;
  int unsigned              sv_idx;

  logic fin_ready, dout_valid, accept, compute_en, finish_en, out_done;
  logic last_label, group_last, score_pos;

  // Beat-level derived values: clamped support count and index of the final MAC group
  always_comb begin
    n_in          = (bus.in_num_sv > CNT_W'(SUP_WIDTH)) ? CNT_W'(SUP_WIDTH) : bus.in_num_sv;
    last_group_in = (n_in == '0) ? '0 : CNT_W'((n_in - CNT_W'(1)) / CNT_W'(NPARALLEL));
    last_label    = (idx_r == IDX_W'(NUM_LABELS-1));
    group_last    = (group_r == last_group_r);
    score         = acc_r + intercept_r;
    score_pos     = !score[ACC_W-1] && (score != '0);
  end

  // Sum of alpha_j * (sv_j . x) over the current group; slots at or past N contribute nothing
  always_comb begin
    group_sum = '0;
    dot       = '0;
    term      = '0;
    sv_idx    = 0;
    for (int unsigned p = 0; p < NPAR_U; p++) begin
      sv_idx = 32'(group_r) * NPAR_U + p;
      dot    = '0;
      if (sv_idx < 32'(n_r)) begin
        for (int unsigned k = 0; k < F_U; k++) begin
          dot = dot + DOT_W'(PROD_W'($signed(support_r[(sv_idx*F_U+k)*NB_U +: NBITS])) *
                             PROD_W'($signed(features_r[k*NB_U +: NBITS])));
        end
        term      = TERM_W'($signed(alpha_r[sv_idx*NB_U +: NBITS])) * TERM_W'(dot);
        group_sum = group_sum + ACC_W'(term);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)         state_next = COMPUTE;
      COMPUTE: if (group_last)     state_next = FINISH;
      FINISH:  state_next = last_label ? DOUT : IDLE;
      DOUT:    if (bus.dout_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs and datapath strobes
  always_comb begin
    fin_ready  = rst && (state == IDLE);
    dout_valid = (state == DOUT);
    accept     = fin_ready && bus.fin_valid;
    compute_en = (state == COMPUTE);
    finish_en  = (state == FINISH);
    out_done   = dout_valid && bus.dout_ready;
  end

  // Beat capture; these only feed the MAC array so they need no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      features_r   <= bus.in_features;
      support_r    <= bus.in_support;
      alpha_r      <= bus.in_alpha;
      intercept_r  <= bus.in_intercept;
      n_r          <= n_in;
      last_group_r <= last_group_in;
    end
  end

  // Accumulator, group counter, label index and result slots
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r    <= '0;
      group_r  <= '0;
      idx_r    <= '0;
      labels_r <= '0;
      scores_r <= '0;
    end else begin
      if (accept) begin
        acc_r   <= '0;
        group_r <= '0;
      end
      if (compute_en) begin
        acc_r   <= acc_r + group_sum;
        group_r <= group_r + CNT_W'(1);
      end
      if (finish_en) begin
        scores_r[32'(idx_r)*ACC_W +: ACC_W] <= score;
        labels_r[idx_r]                     <= score_pos;
        if (!last_label) idx_r <= idx_r + IDX_W'(1);
      end
      if (out_done) idx_r <= '0;
    end
  end

  assign bus.fin_ready   = fin_ready;
  assign bus.dout_valid  = dout_valid;
  assign bus.dout_labels = labels_r;
  assign bus.dout_scores = scores_r;

endmodule

// File: doc/svm_multilabel_seq.md
Name: svm_multilabel_seq

Overview:
- Parametrised successor to the fixed two-label (valence/arousal) linear SVM classifier.
- Classifies NUM_LABELS independent binary labels per entry. Each label gets one input beat carrying features, its support set, alphas, intercept and a runtime support-vector count.
- Computes decision = intercept + sum_j alpha_j * (sv_j · x) sequentially, NPARALLEL support vectors per cycle.
- After the last label, emits all label bits and raw scores on one output handshake.

Parameters:
- NBITS, 5, signed width of feature/support/alpha elements
- F_WIDTH, 4, features per vector
- LOG_F_WIDTH, `ceilLog2(F_WIDTH), clog2 of F_WIDTH (min 0)
- SUP_WIDTH, 164, max support vectors per label
- LOG_SUP_WIDTH, `ceilLog2(SUP_WIDTH), clog2 of SUP_WIDTH
- NPARALLEL, 16, support vectors MACed per compute cycle (1..SUP_WIDTH)
- NUM_LABELS, 2, labels per entry (>=1)
- ACC_W, 3*NBITS+LOG_F_WIDTH+LOG_SUP_WIDTH+1, signed score/intercept width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_features  in  NBITS*F_WIDTH  signed x; element k at [k*NBITS +: NBITS]
- in_support  in  NBITS*SUP_WIDTH*F_WIDTH  sv j, element k at [(j*F_WIDTH+k)*NBITS +: NBITS]
- in_alpha  in  NBITS*SUP_WIDTH  signed alpha_j at [j*NBITS +: NBITS]
- in_intercept  in  ACC_W  signed intercept
- in_num_sv  in  LOG_SUP_WIDTH+1  active support vectors for this beat
- fin_valid  in  1  input beat valid
- fin_ready  out  1  block can accept a beat
- dout_labels  out  NUM_LABELS  bit i = label i
- dout_scores  out  NUM_LABELS*ACC_W  score i at [i*ACC_W +: ACC_W]
- dout_valid  out  1  result valid
- dout_ready  in  1  consumer accepts result

Behaviour:
- Reset (rst=0, async): state IDLE, label index 0, accumulator 0. fin_ready=0 while rst low. dout_valid=0, dout_labels=0, dout_scores=0.
- Reset mid-operation discards partial entries. After release, the first accepted beat is label 0.
- States: IDLE (fin_ready=1), COMPUTE, FINISH, DOUT (dout_valid=1).
- IDLE: on fin_valid&&fin_ready at an edge, register all inputs. Set N=min(in_num_sv,SUP_WIDTH), accumulator=0, group=0, and move to COMPUTE.
- COMPUTE: each cycle adds alpha_j*dot(sv_j,x) for j in [group*NPARALLEL, group*NPARALLEL+NPARALLEL) where j<N; j>=N contributes 0. Runs C=max(1,ceil(N/NPARALLEL)) cycles, then FINISH.
- FINISH (1 cycle): score=acc+intercept, stored in slot idx. label bit = (score > 0); score==0 gives 0. If idx==NUM_LABELS-1 go to DOUT, else idx++ and go to IDLE.
- fin_ready is low for exactly C+1 cycles after each accepting edge when more labels remain.
- DOUT: outputs hold stable while dout_valid&&!dout_ready and fin_ready=0. On the handshake edge: dout_valid=0, idx=0, go to IDLE; fin_ready=1 on the next cycle.
- Arithmetic is fully signed with sign extension. Products are 2*NBITS, dot product 2*NBITS+LOG_F_WIDTH, alpha term 3*NBITS+LOG_F_WIDTH. No saturation; ACC_W is sized to never overflow.
- Inputs are sampled only at the accepting edge; changes afterwards are ignored.
- dout_scores and dout_labels keep their last values outside DOUT; they are only required to be valid when dout_valid=1.

Test Plan:
- F_WIDTH=1, NPARALLEL=16. Label0: x=2, sv={3,-1,4}, alpha={1,2,-1}, num_sv=3, intercept=-1. Label1: x=-3, sv={1}, alpha={2}, num_sv=1, intercept=7. Expected: scores {-7,1}, dout_labels=2'b10, fin_ready low 2 cycles after each accept.
- Score boundary: x=1, sv={1}, alpha={3}, intercept=-3 -> score 0, label 0. Same with intercept=-2 -> score 1, label 1.
- num_sv=0 -> score=intercept after 1 compute cycle. num_sv=17 -> 2 compute cycles (fin_ready low 3). num_sv=200 -> clamped to 164, 11 compute cycles.
- Garbage in sv/alpha slots j>=num_sv (all 15) -> score unchanged versus zero-filled slots.
- Worst case: F_WIDTH=4, all elements -16, alpha -16, num_sv=164, intercept 0 -> score -2686976 exact, label 0.
- dout_ready low 5 cycles -> dout_valid/outputs stable, fin_ready 0. On release, fin_ready=1 next cycle.
- rst pulsed low during label-1 COMPUTE -> all outputs 0 immediately. The next beat is treated as label 0, and the entry completes correctly.
